// File: rtl/systolic_feed_controller.sv
// Input-skew feed sequencer for one systolic tile: clear shifters, load operands, stream, drain, done.
// Optional abort/flush behaviour is enabled by defining FEED_CTRL_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one cycle of sr_clr to wipe stale shifter contents
// LOAD   | read ARRAY_WIDTH words, load_en trails rd_en by one cycle
// STREAM | sr_out_en high for the skewed streaming window
// DRAIN  | wait for the PE pipeline to empty
// DONE   | one-cycle done pulse
// FLUSH  | abort clean-up: sr_clr for one cycle, then IDLE
module systolic_feed_controller #(
  parameter int ARRAY_WIDTH  = 4,
  parameter int DSP_DELAY    = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 8,
  localparam int ADDR_W      = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sr_clr,
  output logic              sr_load_en,
  output logic              sr_out_en
);

  localparam int STREAM_LEN = (DSP_DELAY - 1) * (ARRAY_WIDTH - 1) + ARRAY_WIDTH;
  localparam logic [CNT_W-1:0] LOAD_CNT   = CNT_W'(ARRAY_WIDTH);
  localparam logic [CNT_W-1:0] STREAM_CNT = CNT_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_CNT  = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_STREAM, S_DRAIN, S_DONE, S_FLUSH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             abort_hit;

`ifdef FEED_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Outputs are computed for the state being entered, so every strobe is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      sr_clr     <= 1'b0;
      sr_load_en <= 1'b0;
      sr_out_en  <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_en      <= 1'b0;
      sr_clr     <= 1'b0;
      sr_load_en <= 1'b0;
      sr_out_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            sr_clr <= 1'b1;
          end
        end
        S_DONE, S_FLUSH: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          if (abort_hit) begin
            state  <= S_FLUSH;
            cnt    <= '0;
            sr_clr <= 1'b1;
          end else begin
            case (state)
              S_CLEAR: begin
                state   <= S_LOAD;
                cnt     <= LOAD_CNT;
                rd_en   <= 1'b1;
                rd_addr <= '0;
              end
              S_LOAD: begin
                // Operand buffer has one cycle of read latency.
                sr_load_en <= rd_en;
                if (cnt == '0) begin
                  state     <= S_STREAM;
                  cnt       <= STREAM_CNT;
                  sr_out_en <= 1'b1;
                end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt > CNT_W'(1)) begin
                    rd_en   <= 1'b1;
                    rd_addr <= ADDR_W'(ARRAY_WIDTH + 1 - int'(cnt));
                  end
                end
              end
              S_STREAM: begin
                if (cnt == '0) begin
                  if (DRAIN_CYCLES == 0) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                  end else begin
                    state <= S_DRAIN;
                    cnt   <= DRAIN_CNT;
                  end
                end else begin
                  cnt       <= cnt - 1'b1;
                  sr_out_en <= 1'b1;
                end
              end
              S_DRAIN: begin
                if (cnt == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end else begin
                  cnt <= cnt - 1'b1;
                end
              end
              default: begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/systolic_feed_controller.md
# systolic_feed_controller

Sequencer for one tile of the systolic array's input-skew datapath. On a start request it clears the row/column input shifter registers, fetches one operand vector per lane from the operand buffer, and loads it into the shifters. It then drives the shared out-enable for the skewed streaming window, waits for the PE pipeline to drain, and reports completion. It sits between the top-level tile scheduler and the bank of input shifter registers.

## Interface
- ARRAY_WIDTH, 4, PEs per row/column; also the number of words loaded per shifter.
- DSP_DELAY, 4, PE multiply-accumulate latency; must match the shifters' skew step of DSP_DELAY-1.
- DRAIN_CYCLES, 3, idle cycles after streaming before done; 0 is legal.
- CNT_W, 8, width of the phase counter; must hold the larger of ARRAY_WIDTH+1, STREAM_LEN and DRAIN_CYCLES.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  tile request, sampled only in IDLE.
- abort  in  1  cancel request; behaviour set by the macro in Configuration.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at tile end.
- rd_en  out  1  operand buffer read strobe.
- rd_addr  out  clog2(ARRAY_WIDTH), min 1  operand word index.
- sr_clr  out  1  synchronous clear to all input shifter registers.
- sr_load_en  out  1  shared shifter load enable.
- sr_out_en  out  1  shared shifter out enable.

## Operation
- STREAM_LEN = (DSP_DELAY-1)*(ARRAY_WIDTH-1) + ARRAY_WIDTH. This is the slowest lane's skew plus its word count.
- States: IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE.
- IDLE -> CLEAR when start=1. start in any other state is ignored and not queued.
- CLEAR lasts 1 cycle with sr_clr=1, then goes to LOAD.
- LOAD lasts ARRAY_WIDTH+1 cycles. rd_en=1 with rd_addr 0..ARRAY_WIDTH-1 on the first ARRAY_WIDTH cycles. The operand buffer has 1-cycle read latency, so sr_load_en is rd_en delayed one cycle: high on the last ARRAY_WIDTH cycles of LOAD.
- STREAM: sr_out_en=1 for exactly STREAM_LEN consecutive cycles.
- DRAIN: all strobes low for DRAIN_CYCLES cycles. The state is skipped when DRAIN_CYCLES=0.
- DONE: done=1 for 1 cycle, then IDLE. start in the DONE cycle is ignored. A new start is accepted at the earliest in the following IDLE cycle.
- All outputs are registered. sr_load_en and sr_out_en are never high together. sr_clr is never high with any other strobe.
- The counter reloads on every state entry, with no wrap: it counts down to 0 and the state transitions on 0.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0. busy, done, rd_en, sr_clr, sr_load_en and sr_out_en all 0, rd_addr 0.
- Reset mid-tile drops every strobe immediately. Shifter contents stay stale; the next tile's CLEAR removes them.
- With start sampled high at clock edge E, cycle c0 begins at E and busy=1 in c0.
- Tile latency from c0 to done: 1 + (ARRAY_WIDTH+1) + STREAM_LEN + DRAIN_CYCLES cycles. done falls and busy falls on the same edge.
- rd_addr holds its last value when rd_en=0.

## Configuration
- FEED_CTRL_ABORT_EN defined: abort=1 in CLEAR, LOAD, STREAM or DRAIN behaves as follows.
  - The next cycle is a 1-cycle CLEAR-style flush: sr_clr=1, busy=1, other strobes 0, no done.
  - The controller then returns to IDLE.
  - abort in IDLE or DONE is ignored.
  - If abort and start are high together in IDLE, start wins.
- FEED_CTRL_ABORT_EN undefined: the abort port exists but is ignored, and the tile always runs to done.

## Test plan
- Defaults, start pulse at c0: sr_clr at c0; rd_en at c1..c4 with addr 0,1,2,3; sr_load_en at c2..c5; sr_out_en at c6..c18 (13 cycles); done at c22; busy at c0..c22.
- start held high continuously: second tile's c0 is 2 cycles after the first done (one IDLE cycle in between). No start is accepted during busy.
- DRAIN_CYCLES=0, ARRAY_WIDTH=2, DSP_DELAY=1: STREAM_LEN=2, done at c6, DRAIN never entered.
- rst asserted asynchronously at c10 (mid STREAM): all outputs 0 before the next edge; after release with start, the sequence restarts at CLEAR with the exact timing of the first scenario.
- FEED_CTRL_ABORT_EN defined, abort at c8: sr_clr=1 at c9, IDLE at c10, done never asserted, busy low from c10.
- FEED_CTRL_ABORT_EN undefined, abort at c8: the waveform is identical to the first scenario.
